cnt_s5_down: RTL and testbench
==============================

# cnt_s5_down

Signed down-counter for the Lab06 signed-count datapath; counting from a positive start value toward a negative floor, it is the companion to the existing signed up-counter. It adds a synchronous load, a terminal-count pulse, a saturating wrap counter, and a registered sign/magnitude BCD view for the seven-segment display stage.

## Interface
- W, 5: counter width, two's complement.
- RST_VAL, +10: value loaded on reset; must fit in W signed bits.
- FLOOR, -7: terminal value; the step after FLOOR returns to 0.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable; low forces count to 0.
- load  in  1  synchronous load strobe.
- load_val  in  W  signed value captured on load.
- out_num  out  W  signed current count.
- tc  out  1  high for exactly the cycles in which out_num == FLOOR.
- wrap_cnt  out  8  number of FLOOR→0 wraps since reset, saturating at 255.
- disp_neg  out  1  sign of out_num, delayed 1 cycle.
- disp_tens  out  4  BCD tens of |out_num|, delayed 1 cycle.
- disp_ones  out  4  BCD ones of |out_num|, delayed 1 cycle.

## Operation
- Next-state priority for out_num, evaluated at each rising clk edge:
  1. rst → RST_VAL.
  2. load → load_val.
  3. !en → 0.
  4. out_num == FLOOR → 0, and wrap_cnt increments unless it is already 255.
  5. otherwise → out_num − 1, using W-bit two's-complement arithmetic.
- Below-floor behaviour: a loaded value below FLOOR decrements to −2^(W−1). The next step wraps to +2^(W−1)−1 (for W=5, −16 → +15). This is not a FLOOR wrap and does not change wrap_cnt.
- tc is decoded combinationally from the out_num register (out_num == FLOOR). It is therefore glitch-free relative to clk.
- Display pipeline:
  - Stage register captures disp_neg = out_num[W−1], and mag = |out_num| as a (W)-bit unsigned value.
  - For −2^(W−1), mag = 2^(W−1) (16 for W=5).
  - The tens and ones digits are derived from mag by constant division by 10, then registered.
  - The whole display path is one pipeline stage.
- Reset values:
  - out_num = RST_VAL.
  - wrap_cnt = 0.
  - disp_neg/disp_tens/disp_ones = 0/0/0. The display then shows RST_VAL one cycle after rst deasserts.
- Normal sequence from reset with en=1, load=0: +10, 9, …, 0, −1, …, −7, 0, −1, …, −7, 0, …
  - First pass: 18 cycles from +10 to −7.
  - Steady-state period: 8 cycles (0 to −7).

## Timing
- out_num changes 1 cycle after the qualifying edge. tc follows out_num with no delay.
- Display outputs lag out_num by exactly 1 cycle.
- The wrap_cnt increment occurs on the same edge that moves out_num from FLOOR to 0.
- Simultaneous events:
  - load with en=0: load wins.
  - load while out_num == FLOOR: load wins and wrap_cnt is unchanged.
  - rst with anything: rst wins and all registers take reset values on that edge.
- rst mid-count discards the count and wrap_cnt. The display register also resets, so stale digits are never shown.

## Structure
- Shared package `cnt_pkg` holds:
  - the W default;
  - RST_VAL/FLOOR defaults for the signed counters;
  - the BCD digit width constant (4);
  - the wrap counter width (8).
- One sub-module: `s2bcd_reg`. It takes the signed W-bit input, registers the sign, computes the magnitude, and registers the tens/ones digits. The same sub-module is reused by the up-counter display path.
- Top-level logic is the counter register, the wrap counter and the tc decode.

## Test plan
- Reset, then en=1 for 20 cycles → out_num: +10, 9, …, −7, 0, −1.
  - tc high only at −7.
  - wrap_cnt goes 0 → 1 on the −7→0 edge.
  - disp shows neg=0, tens=1, ones=0 one cycle after reset release.
- Pulse load with load_val=−14, en=1 → sequence −14, −15, −16, +15, 14, …
  - No tc and no wrap_cnt change until −7 is reached.
  - disp for −16 reads neg=1, tens=1, ones=6.
- en dropped for 3 cycles at out_num=4 → out_num 0 for those cycles. Counting resumes 0, −1 after en returns; tc remains low.
- Simultaneous events:
  - load=1 with load_val=5 and en=0 → out_num=5.
  - load=1 while out_num=−7 → next value is load_val and wrap_cnt is unchanged.
  - rst asserted together with load → out_num=+10.
- Run 2100 cycles free-running → wrap_cnt saturates at 255 and never rolls over. tc keeps pulsing every 8 cycles.
- Assert rst mid-count at out_num=−3 with wrap_cnt=4 → on the next edge out_num=+10, wrap_cnt=0, disp=0/0/0. One cycle later disp=0/1/0.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared constants for the Lab06 signed counters and their BCD display paths.
package cnt_pkg;

    localparam int CNT_W     = 5;    // counter width, two's complement
    localparam int S_RST_VAL = 10;   // signed-counter reset value
    localparam int S_FLOOR   = -7;   // signed down-counter terminal value
    localparam int BCD_W     = 4;    // one BCD digit
    localparam int WRAP_W    = 8;    // saturating wrap counter width

endpackage

// File: rtl/cnt_s5_down_s2bcd_reg.sv
// Registered sign/magnitude BCD view of a signed count; shared by the up- and down-counter displays.
module s2bcd_reg
    import cnt_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [W-1:0]  i_val,
    output logic                 o_neg,
    output logic [BCD_W-1:0]     o_tens,
    output logic [BCD_W-1:0]     o_ones
);

    logic [W-1:0]     w_mag;
    logic [W-1:0]     w_tens;
    logic [W-1:0]     w_ones;
    logic             r_neg;
    logic [BCD_W-1:0] r_tens;
    logic [BCD_W-1:0] r_ones;

    // The most negative value negates to itself, which read unsigned is exactly 2^(W-1).
    assign w_mag  = i_val[W-1] ? $unsigned(-i_val) : $unsigned(i_val);
    assign w_tens = w_mag / W'(10);
    assign w_ones = w_mag % W'(10);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg  <= 1'b0;
            r_tens <= '0;
            r_ones <= '0;
        end else begin
            r_neg  <= i_val[W-1];
            r_tens <= BCD_W'(w_tens);
            r_ones <= BCD_W'(w_ones);
        end
    end

    assign o_neg  = r_neg;
    assign o_tens = r_tens;
    assign o_ones = r_ones;

endmodule

// File: rtl/cnt_s5_down.sv
// Signed down-counter toward a negative floor, with load, terminal-count decode,
// saturating wrap counter and a one-stage BCD display view.
module cnt_s5_down
    import cnt_pkg::*;
#(
    parameter int W       = CNT_W,
    parameter int RST_VAL = S_RST_VAL,
    parameter int FLOOR   = S_FLOOR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_load,
    input  logic signed [W-1:0]  i_load_val,
    output logic signed [W-1:0]  o_out_num,
    output logic                 o_tc,
    output logic [WRAP_W-1:0]    o_wrap_cnt,
    output logic                 o_disp_neg,
    output logic [BCD_W-1:0]     o_disp_tens,
    output logic [BCD_W-1:0]     o_disp_ones
);

    localparam logic signed [W-1:0] L_RST   = W'(RST_VAL);
    localparam logic signed [W-1:0] L_FLOOR = W'(FLOOR);

    logic signed [W-1:0] r_count;
    logic [WRAP_W-1:0]   r_wrap;
    logic                w_at_floor;

    assign w_at_floor = (r_count == L_FLOOR);

    // Below-floor values fall through to the plain decrement and wrap naturally at -2^(W-1).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= L_RST;
            r_wrap  <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (!i_en) begin
            r_count <= '0;
        end else if (w_at_floor) begin
            r_count <= '0;
            if (r_wrap != {WRAP_W{1'b1}})
                r_wrap <= r_wrap + 1'b1;
        end else begin
            r_count <= r_count - 1'b1;
        end
    end

    s2bcd_reg #(.W(W)) u_disp (
        .clk    (clk),
        .rst    (rst),
        .i_val  (r_count),
        .o_neg  (o_disp_neg),
        .o_tens (o_disp_tens),
        .o_ones (o_disp_ones)
    );

    assign o_out_num  = r_count;
    assign o_tc       = w_at_floor;
    assign o_wrap_cnt = r_wrap;

endmodule

// File: tb/tb_cnt_s5_down.sv
// Self-checking bench for cnt_s5_down: vector table, directed corner sequences,
// and randomized stimulus against an integer reference model.
module tb_cnt_s5_down;

    logic              clk;
    logic              rst;
    logic              i_en;
    logic              i_load;
    logic signed [4:0] i_load_val;
    logic signed [4:0] o_out_num;
    logic              o_tc;
    logic [7:0]        o_wrap_cnt;
    logic              o_disp_neg;
    logic [3:0]        o_disp_tens;
    logic [3:0]        o_disp_ones;

    cnt_s5_down dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_load      (i_load),
        .i_load_val  (i_load_val),
        .o_out_num   (o_out_num),
        .o_tc        (o_tc),
        .o_wrap_cnt  (o_wrap_cnt),
        .o_disp_neg  (o_disp_neg),
        .o_disp_tens (o_disp_tens),
        .o_disp_ones (o_disp_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, in plain integers.
    int m_cnt  = 0;
    int m_wrap = 0;
    int m_neg  = 0;
    int m_tens = 0;
    int m_ones = 0;

    typedef struct {
        bit rst;
        bit load;
        bit en;
        int lv;
        int e_cnt;
        int e_tc;
        int e_wrap;
    } vec_t;

    vec_t vec[22];
    int   seq20[20] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, -1, -2, -3, -4, -5, -6, -7, 0, -1, -2};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit ld, input bit en, input int lv);
        int mag;
        if (r) begin
            m_neg = 0; m_tens = 0; m_ones = 0;
        end else begin
            m_neg  = (m_cnt < 0) ? 1 : 0;
            mag    = (m_cnt < 0) ? -m_cnt : m_cnt;
            m_tens = mag / 10;
            m_ones = mag % 10;
        end
        if (r) begin
            m_cnt = 10; m_wrap = 0;
        end else if (ld) begin
            m_cnt = lv;
        end else if (!en) begin
            m_cnt = 0;
        end else if (m_cnt == -7) begin
            m_cnt = 0;
            if (m_wrap < 255) m_wrap++;
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt < -16) m_cnt = 15;
        end
    endtask

    // Drive one cycle, advance the model on the edge, compare every output 1 time unit later.
    task automatic apply(input bit r, input bit ld, input bit en, input int lv);
        rst        = r;
        i_load     = ld;
        i_en       = en;
        i_load_val = 5'(lv);
        @(posedge clk);
        model_step(r, ld, en, lv);
        #1;
        check("out_num",   int'(o_out_num), m_cnt);
        check("tc",        int'(o_tc), (m_cnt == -7) ? 1 : 0);
        check("wrap_cnt",  int'(o_wrap_cnt), m_wrap);
        check("disp_neg",  int'(o_disp_neg), m_neg);
        check("disp_tens", int'(o_disp_tens), m_tens);
        check("disp_ones", int'(o_disp_ones), m_ones);
    endtask

    initial begin
        int tc_seen;
        int exp_ld[5] = '{-14, -15, -16, 15, 14};

        for (int i = 0; i < 20; i++)
            vec[i] = '{rst: 0, load: 0, en: 1, lv: 0, e_cnt: seq20[i],
                       e_tc: (i == 16) ? 1 : 0, e_wrap: (i >= 17) ? 1 : 0};
        vec[20] = '{rst: 0, load: 1, en: 0, lv: 5,  e_cnt: 5,  e_tc: 0, e_wrap: 1};
        vec[21] = '{rst: 1, load: 1, en: 1, lv: 3,  e_cnt: 10, e_tc: 0, e_wrap: 0};

        // Reset state.
        apply(1, 0, 0, 0);
        check("rst_out_num", int'(o_out_num), 10);
        check("rst_disp", {o_disp_neg, o_disp_tens, o_disp_ones}, 0);

        // Vector table: first pass, FLOOR wrap, load over en=0, rst over load.
        for (int i = 0; i < 22; i++) begin
            apply(vec[i].rst, vec[i].load, vec[i].en, vec[i].lv);
            check($sformatf("vec%0d_cnt", i),  int'(o_out_num), vec[i].e_cnt);
            check($sformatf("vec%0d_tc", i),   int'(o_tc), vec[i].e_tc);
            check($sformatf("vec%0d_wrap", i), int'(o_wrap_cnt), vec[i].e_wrap);
            if (i == 0)
                check("disp_after_rst", {o_disp_neg, o_disp_tens, o_disp_ones}, 9'h010);
        end

        // Below-floor load walks through -16 and wraps to +15 without a FLOOR wrap.
        apply(0, 1, 1, -14);
        check("ld_cnt0", int'(o_out_num), exp_ld[0]);
        for (int k = 1; k < 5; k++) begin
            apply(0, 0, 1, 0);
            check($sformatf("ld_cnt%0d", k), int'(o_out_num), exp_ld[k]);
            check($sformatf("ld_tc%0d", k), int'(o_tc), 0);
            check($sformatf("ld_wrap%0d", k), int'(o_wrap_cnt), 0);
            if (k == 3)
                check("disp_m16", {o_disp_neg, o_disp_tens, o_disp_ones}, 9'h116);
        end

        // Count 14 -> 4, then drop en for three cycles.
        for (int k = 0; k < 10; k++) apply(0, 0, 1, 0);
        check("at_4", int'(o_out_num), 4);
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 0, 0);
            check($sformatf("en_lo_cnt%0d", k), int'(o_out_num), 0);
            check($sformatf("en_lo_tc%0d", k), int'(o_tc), 0);
        end
        apply(0, 0, 1, 0);
        check("en_resume", int'(o_out_num), -1);

        // Load at FLOOR: load wins and the wrap counter holds.
        for (int k = 0; k < 6; k++) apply(0, 0, 1, 0);
        check("floor_tc", int'(o_tc), 1);
        apply(0, 1, 1, 3);
        check("floor_load_cnt", int'(o_out_num), 3);
        check("floor_load_wrap", int'(o_wrap_cnt), 0);

        // Reset mid-count at -3 with four wraps recorded.
        apply(1, 0, 1, 0);
        for (int k = 0; k < 200; k++) begin
            if (m_wrap == 4 && m_cnt == -3) break;
            apply(0, 0, 1, 0);
        end
        check("mid_cnt", int'(o_out_num), -3);
        check("mid_wrap", int'(o_wrap_cnt), 4);
        apply(1, 0, 1, 0);
        check("mid_rst_cnt", int'(o_out_num), 10);
        check("mid_rst_wrap", int'(o_wrap_cnt), 0);
        check("mid_rst_disp", {o_disp_neg, o_disp_tens, o_disp_ones}, 0);
        apply(0, 0, 1, 0);
        check("mid_rst_disp_next", {o_disp_neg, o_disp_tens, o_disp_ones}, 9'h010);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++)
            apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) != 0), int'($urandom_range(0, 31)) - 16);

        // Free-run from reset long enough to saturate the wrap counter.
        apply(1, 0, 1, 0);
        tc_seen = 0;
        for (int k = 0; k < 2100; k++) begin
            apply(0, 0, 1, 0);
            tc_seen += int'(o_tc);
        end
        check("sat_wrap", int'(o_wrap_cnt), 255);
        check("sat_tc_pulses", tc_seen, 261);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
